counter_rev_param: RTL and testbench

//  Parametrised synchronous up/down (reversible) counter with parallel load, programmable

---
 rtl/counter_rev_param_pkg.sv | 17 +
 rtl/counter_rev_param.sv | 113 +++++++++++
 tb/tb_counter_rev_param.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/counter_rev_param_pkg.sv
// -----------------------------------------------------------------------------
// counter_rev_param_pkg
// Shared encodings for the reversible counter: direction select values on s
// and run-mode values on one_shot. Imported by counter_rev_param and by any
// datapath block that drives those controls.
// -----------------------------------------------------------------------------
package counter_rev_param_pkg;

    // Direction encodings for the s input
    localparam logic DIR_UP       = 1'b1;
    localparam logic DIR_DOWN     = 1'b0;

    // Run-mode encodings for the one_shot input
    localparam logic MODE_FREE    = 1'b0;
    localparam logic MODE_ONESHOT = 1'b1;

endpackage : counter_rev_param_pkg

// File: rtl/counter_rev_param.sv
// -----------------------------------------------------------------------------
// counter_rev_param
// Parametrised synchronous up/down counter with parallel load, programmable
// terminal value (Limit), free-run / one-shot modes and a cascadable ripple
// carry. Instances chain through RC -> ci to build wider counters
// (RC_REG must be 0 for chaining).
//
// Parameters
//   WIDTH    counter width in bits (>= 2)
//   RC_REG   0: RC combinational, 1: RC registered (one cycle late)
//
// Ports
//   clk       rising-edge clock
//   rst_n     synchronous active-low reset
//   en        count enable
//   ci        cascade carry in (tie high when standalone)
//   s         direction, 1 = up, 0 = down
//   Load      synchronous parallel load of PData
//   PData     parallel load value
//   Limit     terminal value (up: 0..Limit, down: Limit..0)
//   one_shot  1: stop at terminal value, 0: wrap
//   cnt       current count
//   RC        ripple carry / borrow at terminal count
//   done      sticky one-shot completion flag
// -----------------------------------------------------------------------------
module counter_rev_param
    import counter_rev_param_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter bit RC_REG = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             ci,
    input  logic             s,
    input  logic             Load,
    input  logic [WIDTH-1:0] PData,
    input  logic [WIDTH-1:0] Limit,
    input  logic             one_shot,
    output logic [WIDTH-1:0] cnt,
    output logic             RC,
    output logic             done
);

    localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic             done_q;
    logic             done_d;
    logic             rc_q;
    logic             term_s;
    logic             blocked_s;
    logic             step_s;
    logic             rc_comb_s;

    // Terminal detect, step qualification and combinational carry
    always_comb begin
        if (s == DIR_UP) begin
            term_s = (cnt_q == Limit);
        end else begin
            term_s = (cnt_q == CNT_ZERO);
        end
        // A completed one-shot blocks further steps until load, reset or free-run
        blocked_s = (one_shot == MODE_ONESHOT) & done_q;
        step_s    = en & ci & ~Load & ~blocked_s;
        // Carry deliberately ignores Load so a loaded terminal value is visible at once
        rc_comb_s = en & ci & term_s & ~blocked_s;
    end

    // Next count / done selection: Load > step > hold
    always_comb begin
        cnt_d  = cnt_q;
        // done is only retained while in one-shot mode; free-run clears it
        done_d = (one_shot == MODE_ONESHOT) & done_q;
        if (Load) begin
            cnt_d  = PData;
            done_d = 1'b0;
        end else if (step_s) begin
            if (term_s && (one_shot == MODE_ONESHOT)) begin
                // Terminal step in one-shot mode: freeze count, flag completion
                cnt_d  = cnt_q;
                done_d = 1'b1;
            end else if (s == DIR_UP) begin
                cnt_d = term_s ? CNT_ZERO : (cnt_q + CNT_ONE);
            end else begin
                cnt_d = term_s ? Limit : (cnt_q - CNT_ONE);
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q  <= CNT_ZERO;
            done_q <= 1'b0;
            rc_q   <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            done_q <= done_d;
            rc_q   <= rc_comb_s;
        end
    end

    assign cnt  = cnt_q;
    assign done = done_q;
    assign RC   = RC_REG ? rc_q : rc_comb_s;

endmodule : counter_rev_param

// File: tb/tb_counter_rev_param.sv
// -----------------------------------------------------------------------------
// tb_counter_rev_param
// Scoreboard bench: stimulus drives inputs on the falling edge and queues the
// state expected after the following rising edge; a monitor samples 1 ns after
// each rising edge and compares against the queue.
// Instances: a 32-bit counter (combinational RC), a two-stage 4-bit cascade
// and a 4-bit counter with registered RC.
// -----------------------------------------------------------------------------
module tb_counter_rev_param;

    typedef struct packed {
        logic [1:0]  sel;   // 0: 32-bit, 1: cascade, 2: registered-RC 4-bit
        logic [31:0] cnt;
        logic        rc;
        logic        done;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        en, ci, s, Load, one_shot;
    logic [31:0] PData, Limit;
    logic [31:0] cnt;
    logic        RC, done;

    logic        c_en, c_load;
    logic [3:0]  lo_cnt, hi_cnt, r_cnt;
    logic        lo_rc, hi_rc, r_rc, lo_done, hi_done, r_done;

    exp_t  exp_q[$];
    string name_q[$];
    int    checks;
    int    fails;

    counter_rev_param #(.WIDTH(32), .RC_REG(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .ci(ci), .s(s), .Load(Load),
        .PData(PData), .Limit(Limit), .one_shot(one_shot),
        .cnt(cnt), .RC(RC), .done(done)
    );

    counter_rev_param #(.WIDTH(4), .RC_REG(1'b0)) u_lo (
        .clk(clk), .rst_n(rst_n), .en(c_en), .ci(1'b1), .s(1'b1), .Load(c_load),
        .PData(4'h0), .Limit(4'hF), .one_shot(1'b0),
        .cnt(lo_cnt), .RC(lo_rc), .done(lo_done)
    );

    counter_rev_param #(.WIDTH(4), .RC_REG(1'b0)) u_hi (
        .clk(clk), .rst_n(rst_n), .en(c_en), .ci(lo_rc), .s(1'b1), .Load(c_load),
        .PData(4'h0), .Limit(4'hF), .one_shot(1'b0),
        .cnt(hi_cnt), .RC(hi_rc), .done(hi_done)
    );

    counter_rev_param #(.WIDTH(4), .RC_REG(1'b1)) u_reg (
        .clk(clk), .rst_n(rst_n), .en(c_en), .ci(1'b1), .s(1'b1), .Load(c_load),
        .PData(4'h0), .Limit(4'hF), .one_shot(1'b0),
        .cnt(r_cnt), .RC(r_rc), .done(r_done)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    task automatic push(input string nm, input logic [1:0] sel,
                        input logic [31:0] c, input logic r, input logic d);
        exp_t e;
        e.sel  = sel;
        e.cnt  = c;
        e.rc   = r;
        e.done = d;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // Queue an expectation for the 32-bit counter and advance one cycle
    task automatic t0(input string nm, input logic [31:0] c, input logic r, input logic d);
        push(nm, 2'd0, c, r, d);
        @(negedge clk);
    endtask

    // Monitor: compare every queued expectation just after the rising edge
    initial begin
        exp_t        e;
        string       nm;
        logic [31:0] a_cnt;
        logic        a_rc, a_done;
        forever begin
            @(posedge clk);
            #1;
            while (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                case (e.sel)
                    2'd0: begin a_cnt = cnt;                     a_rc = RC;    a_done = done;              end
                    2'd1: begin a_cnt = {24'h0, hi_cnt, lo_cnt}; a_rc = hi_rc; a_done = hi_done | lo_done; end
                    default: begin a_cnt = {28'h0, r_cnt};       a_rc = r_rc;  a_done = r_done;            end
                endcase
                checks++;
                if (a_cnt !== e.cnt || a_rc !== e.rc || a_done !== e.done) begin
                    fails++;
                    $display("FAIL %s: got cnt=%h RC=%b done=%b, want cnt=%h RC=%b done=%b",
                             nm, a_cnt, a_rc, a_done, e.cnt, e.rc, e.done);
                end
            end
        end
    end

    initial begin
        int waited;
        logic [7:0] ce;
        checks = 0;
        fails  = 0;

        // 1. reset beats Load
        rst_n = 1'b0; Load = 1'b1; en = 1'b1; ci = 1'b1; s = 1'b1; one_shot = 1'b0;
        PData = 32'h0000_0005; Limit = 32'hFFFF_FFFF; c_en = 1'b0; c_load = 1'b0;
        t0("rst_edge1", 32'h0, 1'b0, 1'b0);
        push("rst_casc", 2'd1, 32'h0, 1'b0, 1'b0);
        push("rst_rcreg", 2'd2, 32'h0, 1'b0, 1'b0);
        t0("rst_edge2", 32'h0, 1'b0, 1'b0);

        // 2. binary up count through the wrap
        rst_n = 1'b1; Load = 1'b1; PData = 32'hFFFF_FFFD;
        t0("up_load", 32'hFFFF_FFFD, 1'b0, 1'b0);
        Load = 1'b0;
        t0("up_fffe", 32'hFFFF_FFFE, 1'b0, 1'b0);
        t0("up_ffff_rc", 32'hFFFF_FFFF, 1'b1, 1'b0);
        t0("up_wrap0", 32'h0, 1'b0, 1'b0);
        t0("up_1", 32'h1, 1'b0, 1'b0);

        // 3. down count, borrow and reversal
        s = 1'b0; Load = 1'b1; PData = 32'h3;
        t0("dn_load3", 32'h3, 1'b0, 1'b0);
        Load = 1'b0;
        t0("dn_2", 32'h2, 1'b0, 1'b0);
        t0("dn_1", 32'h1, 1'b0, 1'b0);
        t0("dn_0_rc", 32'h0, 1'b1, 1'b0);
        t0("dn_wrap_limit", 32'hFFFF_FFFF, 1'b0, 1'b0);
        Load = 1'b1; PData = 32'h2;
        t0("dn_load2", 32'h2, 1'b0, 1'b0);
        Load = 1'b0;
        t0("dn_to1", 32'h1, 1'b0, 1'b0);
        s = 1'b1;
        t0("flip_up_2", 32'h2, 1'b0, 1'b0);

        // 4. one-shot with Limit=9
        Limit = 32'h9; one_shot = 1'b1; Load = 1'b1; PData = 32'h7;
        t0("os_load7", 32'h7, 1'b0, 1'b0);
        Load = 1'b0;
        t0("os_8", 32'h8, 1'b0, 1'b0);
        t0("os_9_rc", 32'h9, 1'b1, 1'b0);
        t0("os_done", 32'h9, 1'b0, 1'b1);
        t0("os_hold", 32'h9, 1'b0, 1'b1);
        one_shot = 1'b0; en = 1'b0;
        t0("os_free_clears", 32'h9, 1'b0, 1'b0);
        one_shot = 1'b1; en = 1'b1;
        t0("os_redone", 32'h9, 1'b0, 1'b1);
        Load = 1'b1; PData = 32'h0;
        t0("os_load0", 32'h0, 1'b0, 1'b0);
        Load = 1'b0; one_shot = 1'b0;
        for (int i = 1; i <= 9; i++) t0("free_up", 32'(i), (i == 9), 1'b0);
        t0("free_wrap", 32'h0, 1'b0, 1'b0);
        s = 1'b0;
        t0("rev_at0_limit", 32'h9, 1'b0, 1'b0);
        t0("rev_dn_8", 32'h8, 1'b0, 1'b0);

        // 5. load above Limit, enable gating
        s = 1'b1; Load = 1'b1; PData = 32'hC;
        t0("big_load12", 32'hC, 1'b0, 1'b0);
        Load = 1'b0;
        t0("big_13", 32'hD, 1'b0, 1'b0);
        en = 1'b0;
        t0("en0_hold", 32'hD, 1'b0, 1'b0);
        en = 1'b1; ci = 1'b0;
        t0("ci0_hold", 32'hD, 1'b0, 1'b0);
        ci = 1'b1; Load = 1'b1; PData = 32'hFFFF_FFFE;
        t0("big_loadfffe", 32'hFFFF_FFFE, 1'b0, 1'b0);
        Load = 1'b0;
        t0("big_ffff", 32'hFFFF_FFFF, 1'b0, 1'b0);
        t0("big_wrap0", 32'h0, 1'b0, 1'b0);
        t0("big_1", 32'h1, 1'b0, 1'b0);
        en = 1'b0; Load = 1'b1; PData = 32'h9;
        t0("term_en0_rc0", 32'h9, 1'b0, 1'b0);
        en = 1'b1; ci = 1'b0; Load = 1'b0;
        t0("term_ci0_rc0", 32'h9, 1'b0, 1'b0);
        ci = 1'b1;

        // reset during one-shot hold
        one_shot = 1'b1; Load = 1'b1; PData = 32'h9;
        t0("osr_load9", 32'h9, 1'b1, 1'b0);
        Load = 1'b0;
        t0("osr_done", 32'h9, 1'b0, 1'b1);
        rst_n = 1'b0;
        t0("osr_reset", 32'h0, 1'b0, 1'b0);
        rst_n = 1'b1;
        t0("osr_restart", 32'h1, 1'b0, 1'b0);

        // Limit = 0 holds at 0 in both directions with RC on every step
        one_shot = 1'b0; Limit = 32'h0; Load = 1'b1; PData = 32'h0;
        t0("lim0_load", 32'h0, 1'b1, 1'b0);
        Load = 1'b0;
        t0("lim0_up", 32'h0, 1'b1, 1'b0);
        s = 1'b0;
        t0("lim0_dn", 32'h0, 1'b1, 1'b0);
        en = 1'b0;

        // 6. cascade of two 4-bit stages and registered-RC stage
        c_en = 1'b1;
        for (int i = 1; i <= 256; i++) begin
            ce = 8'(i);
            push("casc", 2'd1, {24'h0, ce}, (ce == 8'hFF), 1'b0);
            push("rcreg", 2'd2, {28'h0, ce[3:0]}, (ce[3:0] == 4'h0), 1'b0);
            @(negedge clk);
        end
        c_en = 1'b0;

        // drain the scoreboard with a bounded wait
        waited = 0;
        while (exp_q.size() > 0 && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        if (exp_q.size() > 0) begin
            checks++;
            fails++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule : tb_counter_rev_param
